// File: rtl/mcp_bus_ctrl_if.sv
// Host-side handshake and memory-side pin bundle for mcp_bus_ctrl.
// The controller connects through the slave modport; the host/memory model uses master.
interface mcp_bus_ctrl_if #(
    parameter int AB  = 22,
    parameter int W   = 16,
    parameter int NCS = 2
);
    logic           REQ;
    logic           WR;
    logic [NCS-1:0] SEL;
    logic [AB-1:0]  ADDR;
    logic [W-1:0]   WDATA;
    logic           BYTE;
    logic           ACK;
    logic           ERR;
    logic [W-1:0]   RDATA;
    logic           BUSY;
    logic           CFG_ERR;
    logic [AB-1:0]  MA;
    logic [W-1:0]   MDQ_O;
    logic           MDQ_OE;
    logic [W-1:0]   MDQ_I;
    logic [NCS-1:0] XCE;
    logic           XOE;
    logic           XWE;
    logic           CIO;

    modport slave (
        input  REQ, WR, SEL, ADDR, WDATA, BYTE, MDQ_I,
        output ACK, ERR, RDATA, BUSY, CFG_ERR, MA, MDQ_O, MDQ_OE, XCE, XOE, XWE, CIO
    );

    modport master (
        output REQ, WR, SEL, ADDR, WDATA, BYTE, MDQ_I,
        input  ACK, ERR, RDATA, BUSY, CFG_ERR, MA, MDQ_O, MDQ_OE, XCE, XOE, XWE, CIO
    );
endinterface

// File: rtl/mcp_bus_ctrl.sv
// Multi-chip parallel memory bus controller: timed SETUP/PULSE/HOLD/RECOV strobe sequencing
// with one shared phase counter; every pin-level output is a register.
module mcp_bus_ctrl #(
    parameter int AB      = 22,
    parameter int W       = 16,
    parameter int NCS     = 2,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 3,
    parameter int T_HOLD  = 1,
    parameter int T_RECOV = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    mcp_bus_ctrl_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_onehot(input logic [NCS-1:0] v);
        return (v != {NCS{1'b0}}) && ((v & (v - NCS'(1))) == {NCS{1'b0}});
    endfunction

    localparam int TMAX = max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_RECOV));
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_RECOV = 3'd4
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_wr;
    logic [NCS-1:0] r_sel;
    logic [AB-1:0]  r_ma;
    logic [W-1:0]   r_mdq_o;
    logic [NCS-1:0] r_xce;
    logic           r_xoe;
    logic           r_xwe;
    logic           r_mdq_oe;
    logic           r_ack;
    logic           r_err;
    logic           r_busy;
    logic [W-1:0]   r_rdata;
    logic           r_byte_mode;
    logic           r_cio;
    logic           r_cfg_err;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_latch;
    logic           w_ack_nxt;
    logic           w_err_nxt;
    logic           w_wr_src;
    logic [NCS-1:0] w_sel_src;
    logic           w_ce_act;
    logic [NCS-1:0] w_xce_nxt;
    logic           w_xoe_nxt;
    logic           w_xwe_nxt;
    logic           w_oe_nxt;
    logic           w_rd_cap;
    logic [W-1:0]   w_byte_mask;

    // Next-state/counter sequencing plus look-ahead decode of the registered pin outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.REQ) begin
                    w_latch = 1'b1;
                    if (is_onehot(bus.SEL)) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = CW'(T_SETUP - 1);
                    end else begin
                        w_state_nxt = S_RECOV;
                        w_cnt_nxt   = CW'(T_RECOV - 1);
                        w_ack_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = CW'(T_PULSE - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CW'(T_HOLD - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_RECOV;
                    w_cnt_nxt   = CW'(T_RECOV - 1);
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RECOV: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CW'(0);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CW'(0);
            end
        endcase

        if (w_latch) begin
            w_wr_src  = bus.WR;
            w_sel_src = bus.SEL;
        end else begin
            w_wr_src  = r_wr;
            w_sel_src = r_sel;
        end

        // Illegal selects go straight to RECOV, so w_ce_act never drives a non-one-hot pattern.
        w_ce_act  = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) || (w_state_nxt == S_HOLD);
        if (w_ce_act) begin
            w_xce_nxt = ~w_sel_src;
        end else begin
            w_xce_nxt = {NCS{1'b1}};
        end
        w_xoe_nxt = !((w_state_nxt == S_PULSE) && !w_wr_src);
        w_xwe_nxt = !((w_state_nxt == S_PULSE) && w_wr_src);
        w_oe_nxt  = w_ce_act && w_wr_src;
        w_rd_cap  = (r_state == S_PULSE) && (r_cnt == CW'(0)) && !r_wr;

        if (r_byte_mode) begin
            w_byte_mask = W'(8'hFF);
        end else begin
            w_byte_mask = {W{1'b1}};
        end
    end

    // FSM state and shared phase counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= CW'(0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request latches, registered pin outputs and read-data capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr     <= 1'b0;
            r_sel    <= {NCS{1'b0}};
            r_ma     <= {AB{1'b0}};
            r_mdq_o  <= {W{1'b0}};
            r_xce    <= {NCS{1'b1}};
            r_xoe    <= 1'b1;
            r_xwe    <= 1'b1;
            r_mdq_oe <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata  <= {W{1'b0}};
        end else begin
            if (w_latch) begin
                r_wr    <= bus.WR;
                r_sel   <= bus.SEL;
                r_ma    <= bus.ADDR;
                r_mdq_o <= bus.WDATA;
            end
            if (w_rd_cap) begin
                r_rdata <= bus.MDQ_I & w_byte_mask;
            end
            r_xce    <= w_xce_nxt;
            r_xoe    <= w_xoe_nxt;
            r_xwe    <= w_xwe_nxt;
            r_mdq_oe <= w_oe_nxt;
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    // Bus width is fixed by BYTE at reset; any later change of BYTE is flagged, never applied.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_byte_mode <= bus.BYTE;
            r_cio       <= ~bus.BYTE;
            r_cfg_err   <= 1'b0;
        end else if (bus.BYTE != r_byte_mode) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign bus.ACK     = r_ack;
    assign bus.ERR     = r_err;
    assign bus.RDATA   = r_rdata;
    assign bus.BUSY    = r_busy;
    assign bus.CFG_ERR = r_cfg_err;
    assign bus.MA      = r_ma;
    assign bus.MDQ_O   = r_mdq_o;
    assign bus.MDQ_OE  = r_mdq_oe;
    assign bus.XCE     = r_xce;
    assign bus.XOE     = r_xoe;
    assign bus.XWE     = r_xwe;
    assign bus.CIO     = r_cio;

endmodule
